// File: rtl/cart_dl_arbiter_if.sv
// rtl/cart_dl_arbiter_if.sv - CPU cart-window and cart-memory handshake bundle
//
// Carries the two request/ack ports that the download arbiter sits between.
//   cpu_req/cpu_we/cpu_addr/cpu_din : CPU cart access, req held until cpu_ack
//   cpu_dout/cpu_ack                : read data and one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_dout: memory request, held until mem_ack
//   mem_din/mem_ack                 : memory read data and one-cycle completion
// master: the arbiter's view (drives mem_*, cpu_dout, cpu_ack).
// slave : the surrounding system's view (CPU decode plus memory client).
interface cart_dl_arbiter_if #(
  parameter int ADDR_W = 15
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_din;
  logic [7:0]        cpu_dout;
  logic              cpu_ack;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_dout;
  logic [7:0]        mem_din;
  logic              mem_ack;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_din, mem_din, mem_ack,
    output cpu_dout, cpu_ack, mem_req, mem_we, mem_addr, mem_dout
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_din, mem_din, mem_ack,
    input  cpu_dout, cpu_ack, mem_req, mem_we, mem_addr, mem_dout
  );
endinterface

// File: rtl/cart_dl_arbiter.sv
// rtl/cart_dl_arbiter.sv - cartridge download sequencer and cart memory arbiter
//
// Buffers cartridge bytes from the HPS ioctl stream in a small FIFO, writes
// them into the shared cart memory, and shares that memory port with CPU cart
// accesses. The CPU is held off while a download is active or still draining.
//
// Ports:
//   CLK50MHZ, COCO_RESET_N : clock, asynchronous active-low reset
//   ioctl_download/index/wr/addr/data : HPS download stream
//   bus (master)           : CPU request/ack and memory request/ack bundle
//   cpu_hold               : CPU must stay halted
//   cart_present           : a non-empty image has been fully written
//   dl_overflow, dl_trunc  : sticky byte-loss flags, cleared at download start
//   dl_sum                 : 16-bit sum of accepted bytes (DL_CHECKSUM_EN only)
//
// Optional feature macro: DL_CHECKSUM_EN adds the dl_sum output and its adder.
module cart_dl_arbiter #(
  parameter int         ADDR_W     = 15,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] DL_INDEX   = 8'd1
) (
  input  logic         CLK50MHZ,
  input  logic         COCO_RESET_N,
  input  logic         ioctl_download,
  input  logic [7:0]   ioctl_index,
  input  logic         ioctl_wr,
  input  logic [24:0]  ioctl_addr,
  input  logic [7:0]   ioctl_data,
  cart_dl_arbiter_if.master bus,
  output logic         cpu_hold,
  output logic         cart_present,
  output logic         dl_overflow,
  output logic         dl_trunc
`ifdef DL_CHECKSUM_EN
  ,
  output logic [15:0]  dl_sum
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_URGENT = CNT_W'(FIFO_DEPTH - 2);

  typedef enum logic [1:0] {S_IDLE, S_CPU, S_DL} state_t;

  state_t state, state_nxt;
  logic   grant_dl, grant_cpu;

  logic dl_active, dl_active_q, dl_start, dl_end;
  logic in_range, wr_hit, push, pop;
  logic fifo_empty, fifo_full;
  logic hold_int;
  logic pushed_any, armed;

  logic [ADDR_W+7:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_data;

  assign dl_active = ioctl_download && (ioctl_index == DL_INDEX);
  assign dl_start  = dl_active && !dl_active_q;
  assign dl_end    = !dl_active && dl_active_q;

  // Upper address bits only qualify the byte; they never reach the memory.
  assign in_range  = (ioctl_addr[24:ADDR_W] == '0);
  assign wr_hit    = ioctl_wr && dl_active;
  assign push      = wr_hit && in_range && !fifo_full;
  assign pop       = (state == S_DL) && bus.mem_ack;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_FULL);

  assign hold_int = dl_active || !fifo_empty || (state == S_DL);
  // Forced low while reset is asserted so every output reads 0 in reset.
  assign cpu_hold = COCO_RESET_N && hold_int;

  assign bus.mem_req  = (state != S_IDLE);
  assign bus.mem_we   = req_we;
  assign bus.mem_addr = req_addr;
  assign bus.mem_dout = req_data;

  always_ff @(posedge CLK50MHZ or negedge COCO_RESET_N) begin
    if (!COCO_RESET_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Only IDLE grants, so every transaction is followed by a mem_req-low cycle.
  // A CPU grant is also blocked while cpu_ack is out: the CPU still holds
  // cpu_req during that cycle and must not be served twice.
  always_comb begin
    state_nxt = state;
    grant_dl  = 1'b0;
    grant_cpu = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty && (hold_int || count >= CNT_URGENT)) begin
          grant_dl  = 1'b1;
          state_nxt = S_DL;
        end else if (bus.cpu_req && !hold_int && !bus.cpu_ack) begin
          grant_cpu = 1'b1;
          state_nxt = S_CPU;
        end
      end
      S_CPU:   if (bus.mem_ack) state_nxt = S_IDLE;
      S_DL:    if (bus.mem_ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK50MHZ) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {ioctl_addr[ADDR_W-1:0], ioctl_data};
    end
  end

  always_ff @(posedge CLK50MHZ or negedge COCO_RESET_N) begin
    if (!COCO_RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Request fields are captured at grant and stay put until the ack.
  always_ff @(posedge CLK50MHZ or negedge COCO_RESET_N) begin
    if (!COCO_RESET_N) begin
      req_we       <= 1'b0;
      req_addr     <= '0;
      req_data     <= '0;
      bus.cpu_dout <= '0;
      bus.cpu_ack  <= 1'b0;
    end else begin
      bus.cpu_ack <= 1'b0;
      if (grant_dl) begin
        req_we               <= 1'b1;
        {req_addr, req_data} <= fifo_mem[rd_ptr];
      end else if (grant_cpu) begin
        req_we   <= bus.cpu_we;
        req_addr <= bus.cpu_addr;
        req_data <= bus.cpu_din;
      end
      if ((state == S_CPU) && bus.mem_ack) begin
        bus.cpu_dout <= bus.mem_din;
        bus.cpu_ack  <= 1'b1;
      end
    end
  end

  // armed: the download has ended with bytes pushed; cart_present follows
  // once the FIFO is drained and the last DL write has been acked.
  always_ff @(posedge CLK50MHZ or negedge COCO_RESET_N) begin
    if (!COCO_RESET_N) begin
      dl_active_q  <= 1'b0;
      cart_present <= 1'b0;
      dl_overflow  <= 1'b0;
      dl_trunc     <= 1'b0;
      pushed_any   <= 1'b0;
      armed        <= 1'b0;
    end else begin
      dl_active_q <= dl_active;
      if (dl_start) begin
        cart_present <= 1'b0;
        dl_overflow  <= 1'b0;
        dl_trunc     <= 1'b0;
        pushed_any   <= 1'b0;
        armed        <= 1'b0;
      end
      if (wr_hit && !in_range)             dl_trunc    <= 1'b1;
      if (wr_hit && in_range && fifo_full) dl_overflow <= 1'b1;
      if (push)                            pushed_any  <= 1'b1;
      if (dl_end) begin
        armed <= pushed_any;
      end else if (armed && !hold_int) begin
        cart_present <= 1'b1;
        armed        <= 1'b0;
      end
    end
  end

`ifdef DL_CHECKSUM_EN
  always_ff @(posedge CLK50MHZ or negedge COCO_RESET_N) begin
    if (!COCO_RESET_N) begin
      dl_sum <= '0;
    end else if (dl_start) begin
      dl_sum <= push ? {8'h00, ioctl_data} : 16'h0000;
    end else if (push) begin
      dl_sum <= dl_sum + {8'h00, ioctl_data};
    end
  end
`endif

endmodule

// File: tb/tb_cart_dl_arbiter.sv
// tb/tb_cart_dl_arbiter.sv - self-checking bench for cart_dl_arbiter
module tb_cart_dl_arbiter;

  typedef struct packed {
    logic [14:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        cpu_hold, cart_present, dl_overflow, dl_trunc;
`ifdef DL_CHECKSUM_EN
  logic [15:0] dl_sum;
`endif

  cart_dl_arbiter_if #(.ADDR_W(15)) bus ();

  cart_dl_arbiter dut (
    .CLK50MHZ       (clk),
    .COCO_RESET_N   (rst_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_data     (ioctl_data),
    .bus            (bus),
    .cpu_hold       (cpu_hold),
    .cart_present   (cart_present),
    .dl_overflow    (dl_overflow),
    .dl_trunc       (dl_trunc)
`ifdef DL_CHECKSUM_EN
    ,
    .dl_sum         (dl_sum)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory responder state (written only by the responder process).
  int          ack_delay = 3;
  int          ack_cnt = 0;
  bit          ack_prev = 0;
  int          manual_req = 0;
  int          manual_done = 0;
  int          gap_viol = 0;
  int          stab_viol = 0;
  logic        held_we;
  logic [14:0] held_addr;
  logic [7:0]  held_data;
  logic [7:0]  mem_w [int];
  wr_t         wr_log [$];

  // Reference model of cart memory content and download stimulus.
  logic [7:0]  ref_mem [int];
  logic [24:0] dl_addr [$];
  logic [7:0]  dl_data [$];

  function automatic logic [7:0] init_pat(input int a);
    return (a == 16) ? 8'hA5 : 8'(a * 7 + 3);
  endfunction

  function automatic logic [7:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_pat(a);
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      bus.mem_ack = 1'b0;
      ack_cnt     = 0;
      ack_prev    = 0;
    end else begin
      if (ack_prev && bus.mem_req) gap_viol++;
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        ack_cnt     = 0;
      end else if (manual_req != manual_done) begin
        manual_done = manual_req;
        bus.mem_ack = 1'b1;
        bus.mem_din = 8'h5A;
      end else if (bus.mem_req) begin
        if (ack_cnt == 0) begin
          held_we = bus.mem_we; held_addr = bus.mem_addr; held_data = bus.mem_dout;
        end else if (held_we !== bus.mem_we || held_addr !== bus.mem_addr ||
                     (held_we && held_data !== bus.mem_dout)) begin
          stab_viol++;
        end
        if (ack_cnt >= ack_delay) begin
          bus.mem_ack = 1'b1;
          ack_cnt     = 0;
          if (bus.mem_we) begin
            mem_w[int'(bus.mem_addr)] = bus.mem_dout;
            wr_log.push_back(wr_t'{bus.mem_addr, bus.mem_dout});
          end else begin
            bus.mem_din = mem_w.exists(int'(bus.mem_addr)) ? mem_w[int'(bus.mem_addr)]
                                                           : init_pat(int'(bus.mem_addr));
          end
        end else begin
          ack_cnt++;
        end
      end
      ack_prev = bus.mem_ack;
    end
  end

  task automatic cpu_access(input bit we, input logic [14:0] a, input logic [7:0] d,
                            output logic [7:0] q, output bit ok);
    int n;
    n = 0; ok = 0; q = 8'h00;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_din = d;
    while (n < 300 && !ok) begin
      @(negedge clk);
      n++;
      if (bus.cpu_ack) begin
        q  = bus.cpu_dout;
        ok = 1;
      end
    end
    bus.cpu_req = 1'b0;
  endtask

  // Sends dl_addr/dl_data, ends the download and waits for cpu_hold to drop.
  task automatic run_download(input logic [7:0] idx, input int gap, output bit timeout,
                              output int hold_cyc, output int wr_at_release);
    int n;
    hold_cyc = 0; timeout = 1; wr_at_release = -1;
    @(negedge clk);
    ioctl_download = 1'b1; ioctl_index = idx;
    @(negedge clk);
    foreach (dl_addr[i]) begin
      ioctl_wr = 1'b1; ioctl_addr = dl_addr[i]; ioctl_data = dl_data[i];
      @(negedge clk);
      ioctl_wr = 1'b0;
      if (cpu_hold) hold_cyc++;
      repeat (gap) @(negedge clk);
    end
    ioctl_download = 1'b0;
    n = 0;
    while (n < 3000 && timeout) begin
      @(negedge clk);
      n++;
      if (cpu_hold) hold_cyc++;
      else begin
        timeout = 0;
        wr_at_release = wr_log.size();
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] q;
    bit ok;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.cpu_dout, bus.cpu_ack, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_dout,
         cpu_hold, cart_present, dl_overflow, dl_trunc} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b hold=%b present=%b ovf=%b trunc=%b ack=%b, required all 0",
               bus.mem_req, cpu_hold, cart_present, dl_overflow, dl_trunc, bus.cpu_ack);
    end
    cpu_access(1'b0, 15'h0010, 8'h00, q, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL first_read_ack: got no cpu_ack, required one");
    end
    checks++;
    if (q !== 8'hA5) begin
      errors++; $display("FAIL first_read_data: got %h required a5", q);
    end
  endtask

  task automatic test_download();
    bit to; int hc, war, base;
    wr_t exp [4];
    ack_delay = 3;
    dl_addr = {25'h0, 25'h1, 25'h2, 25'h3};
    dl_data = {8'h12, 8'h34, 8'h56, 8'h78};
    for (int i = 0; i < 4; i++) begin
      exp[i] = wr_t'{15'(i), dl_data[i]};
      ref_mem[i] = dl_data[i];
    end
    base = wr_log.size();
    run_download(8'd1, 1, to, hc, war);
    checks++;
    if (to) begin errors++; $display("FAIL dl_hold_release: cpu_hold never dropped"); end
    checks++;
    if (war - base != 4) begin
      errors++; $display("FAIL dl_hold_until_last_ack: got %0d writes at release, required 4", war - base);
    end
    checks++;
    if (wr_log.size() - base != 4) begin
      errors++; $display("FAIL dl_write_count: got %0d required 4", wr_log.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_log[base + i] !== exp[i]) begin
          errors++; $display("FAIL dl_write_%0d: got %h required %h", i, wr_log[base + i], exp[i]);
        end
      end
    end
    checks++;
    if (cart_present !== 1'b1) begin
      errors++; $display("FAIL dl_cart_present: got %b required 1", cart_present);
    end
`ifdef DL_CHECKSUM_EN
    checks++;
    if (dl_sum !== 16'h0114) begin
      errors++; $display("FAIL dl_sum: got %h required 0114", dl_sum);
    end
`endif
  endtask

  task automatic test_other_index();
    bit to; int hc, war, base;
    dl_addr = {25'h10, 25'h11, 25'h12};
    dl_data = {8'hDE, 8'hAD, 8'hBE};
    base = wr_log.size();
    run_download(8'd2, 0, to, hc, war);
    checks++;
    if (wr_log.size() != base) begin
      errors++; $display("FAIL idx2_no_writes: got %0d writes required 0", wr_log.size() - base);
    end
    checks++;
    if (hc != 0) begin
      errors++; $display("FAIL idx2_no_hold: got %0d hold cycles required 0", hc);
    end
    checks++;
    if (cart_present !== 1'b1) begin
      errors++; $display("FAIL idx2_present_kept: got %b required 1", cart_present);
    end
  endtask

  task automatic test_hold_cpu();
    int n, hold_clear_n, ack_n;
    logic [7:0] q;
    ack_delay = 10;
    hold_clear_n = -1; ack_n = -1; q = 8'h00;
    @(negedge clk);
    ioctl_download = 1'b1; ioctl_index = 8'd1;
    @(negedge clk);
    ioctl_wr = 1'b1; ioctl_addr = 25'h40; ioctl_data = 8'h9C;
    ref_mem[32'h40] = 8'h9C;
    @(negedge clk);
    ioctl_wr = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 15'h40; bus.cpu_din = 8'h00;
    n = 0;
    while (n < 400 && ack_n < 0) begin
      @(negedge clk);
      n++;
      if (n == 6) ioctl_download = 1'b0;
      if (!cpu_hold && hold_clear_n < 0) hold_clear_n = n;
      if (bus.cpu_ack) begin
        ack_n = n;
        q = bus.cpu_dout;
      end
    end
    bus.cpu_req = 1'b0;
    checks++;
    if (ack_n < 0) begin
      errors++; $display("FAIL held_cpu_ack: got no ack required one");
    end else begin
      checks++;
      if (hold_clear_n < 0 || ack_n <= hold_clear_n) begin
        errors++; $display("FAIL held_cpu_order: got ack at %0d, hold cleared at %0d", ack_n, hold_clear_n);
      end
      checks++;
      if (q !== 8'h9C) begin
        errors++; $display("FAIL held_cpu_data: got %h required 9c", q);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [14:0] a;
    logic [7:0]  d, q, e;
    bit          we, ok;
    for (int i = 0; i < 30; i++) begin
      ack_delay = $urandom_range(4, 0);
      we = 1'($urandom_range(1, 0));
      a  = 15'($urandom_range(32'h7FF, 0));
      d  = 8'($urandom);
      e  = ref_rd(int'(a));
      cpu_access(we, a, d, q, ok);
      if (we) ref_mem[int'(a)] = d;
      checks++;
      if (!ok) begin
        errors++; $display("FAIL b2b_ack_%0d: got no cpu_ack required one", i);
      end else if (!we) begin
        checks++;
        if (q !== e) begin
          errors++; $display("FAIL b2b_read_%0d: addr %h got %h required %h", i, a, q, e);
        end
      end
    end
    checks++;
    if (gap_viol != 0) begin
      errors++; $display("FAIL idle_gap: got %0d back-to-back requests required 0", gap_viol);
    end
    checks++;
    if (stab_viol != 0) begin
      errors++; $display("FAIL req_stable: got %0d field changes required 0", stab_viol);
    end
  endtask

  task automatic test_random_download();
    bit to; int hc, war, base, n;
    logic [24:0] a;
    logic [7:0]  d;
    logic [15:0] sum;
    bit          any_out;
    wr_t         exp [$];
    for (int it = 0; it < 4; it++) begin
      dl_addr.delete(); dl_data.delete(); exp.delete();
      sum = 16'h0; any_out = 0;
      ack_delay = $urandom_range(4, 0);
      n = $urandom_range(8, 1);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(3, 0) == 0) a = 25'(32'h8000 + $urandom_range(32'h1FFFFF, 0));
        else a = 25'($urandom_range(32'h7FFF, 0));
        d = 8'($urandom);
        dl_addr.push_back(a); dl_data.push_back(d);
        if (a < 25'h8000) begin
          exp.push_back(wr_t'{a[14:0], d});
          sum += 16'(d);
          ref_mem[int'(a)] = d;
        end else begin
          any_out = 1;
        end
      end
      base = wr_log.size();
      run_download(8'd1, $urandom_range(3, 0), to, hc, war);
      checks++;
      if (to || war - base != exp.size()) begin
        errors++; $display("FAIL rnd%0d_release: timeout=%b writes=%0d required %0d", it, to, war - base, exp.size());
      end
      checks++;
      if (wr_log.size() - base != exp.size()) begin
        errors++; $display("FAIL rnd%0d_count: got %0d required %0d", it, wr_log.size() - base, exp.size());
      end else begin
        foreach (exp[i]) begin
          checks++;
          if (wr_log[base + i] !== exp[i]) begin
            errors++; $display("FAIL rnd%0d_write_%0d: got %h required %h", it, i, wr_log[base + i], exp[i]);
          end
        end
      end
      checks++;
      if (dl_trunc !== any_out || cart_present !== (exp.size() > 0) || dl_overflow !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_flags: trunc=%b present=%b ovf=%b required %b %b 0",
                           it, dl_trunc, cart_present, dl_overflow, any_out, exp.size() > 0);
      end
`ifdef DL_CHECKSUM_EN
      checks++;
      if (dl_sum !== sum) begin
        errors++; $display("FAIL rnd%0d_sum: got %h required %h", it, dl_sum, sum);
      end
`endif
    end
  endtask

  task automatic test_trunc();
    bit to; int hc, war, base;
    ack_delay = 2;
    dl_addr = {25'h8000}; dl_data = {8'h11};
    base = wr_log.size();
    run_download(8'd1, 1, to, hc, war);
    checks++;
    if (dl_trunc !== 1'b1 || cart_present !== 1'b0 || wr_log.size() != base) begin
      errors++; $display("FAIL trunc_only: trunc=%b present=%b writes=%0d required 1 0 0",
                         dl_trunc, cart_present, wr_log.size() - base);
    end
    dl_addr = {25'h8000, 25'h0005}; dl_data = {8'h22, 8'h33};
    ref_mem[5] = 8'h33;
    base = wr_log.size();
    run_download(8'd1, 1, to, hc, war);
    checks++;
    if (dl_trunc !== 1'b1 || cart_present !== 1'b1 || wr_log.size() != base + 1) begin
      errors++; $display("FAIL trunc_mixed: trunc=%b present=%b writes=%0d required 1 1 1",
                         dl_trunc, cart_present, wr_log.size() - base);
    end else begin
      checks++;
      if (wr_log[base] !== wr_t'{15'h5, 8'h33}) begin
        errors++; $display("FAIL trunc_write: got %h required 000533", wr_log[base]);
      end
    end
  endtask

  task automatic test_overflow();
    bit to; int hc, war, base;
    ack_delay = 20;
    dl_addr.delete(); dl_data.delete();
    for (int i = 0; i < 12; i++) begin
      dl_addr.push_back(25'(32'h200 + i));
      dl_data.push_back(8'($urandom));
    end
    for (int i = 0; i < 8; i++) ref_mem[32'h200 + i] = dl_data[i];
    base = wr_log.size();
    run_download(8'd1, 0, to, hc, war);
    checks++;
    if (dl_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_flag: got %b required 1", dl_overflow);
    end
    checks++;
    if (wr_log.size() - base != 8) begin
      errors++; $display("FAIL ovf_count: got %0d required 8", wr_log.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (wr_log[base + i] !== wr_t'{15'(32'h200 + i), dl_data[i]}) begin
          errors++; $display("FAIL ovf_write_%0d: got %h", i, wr_log[base + i]);
        end
      end
    end
    @(negedge clk);
    ioctl_download = 1'b1; ioctl_index = 8'd1;
    repeat (2) @(negedge clk);
    checks++;
    if (dl_overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got %b required 0", dl_overflow);
    end
    ioctl_download = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (cart_present !== 1'b0) begin
      errors++; $display("FAIL empty_dl_present: got %b required 0", cart_present);
    end
  endtask

  task automatic test_reset_midflight();
    int n, ackc, base;
    bit seen;
    ack_delay = 40;
    @(negedge clk);
    ioctl_download = 1'b1; ioctl_index = 8'd1;
    @(negedge clk);
    ioctl_wr = 1'b1; ioctl_addr = 25'h100; ioctl_data = 8'h3C;
    @(negedge clk);
    ioctl_wr = 1'b0;
    n = 0; seen = 0;
    while (n < 20 && !seen) begin
      @(negedge clk);
      n++;
      seen = bus.mem_req;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_dl_req: got no mem_req required one"); end
    #5;
    rst_n = 1'b0;
    ioctl_download = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || cpu_hold !== 1'b0) begin
      errors++; $display("FAIL rst_async: mem_req=%b cpu_hold=%b required 0 0", bus.mem_req, cpu_hold);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = wr_log.size();
    manual_req++;
    ackc = 0; seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.cpu_ack) ackc++;
      if (bus.mem_req) seen = 1;
    end
    checks++;
    if (ackc != 0 || seen || cpu_hold !== 1'b0 || wr_log.size() != base) begin
      errors++; $display("FAIL rst_stale_ack: cpu_acks=%0d mem_req_seen=%b hold=%b writes=%0d required 0 0 0 0",
                         ackc, seen, cpu_hold, wr_log.size() - base);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_data = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
    bus.mem_din = '0; bus.mem_ack = 1'b0;
    test_reset();
    test_download();
    test_other_index();
    test_hold_cpu();
    test_back_to_back();
    test_random_download();
    test_trunc();
    test_overflow();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
